// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: one shared memory port for instruction fetch and
// data accesses, with data priority, fetch starvation relief and an ack timeout.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_done,
    output logic                if_err,
    output logic [DATA_W-1:0]   if_rdata,

    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic                dm_done,
    output logic                dm_err,
    output logic [DATA_W-1:0]   dm_rdata,

    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                busy
);

    localparam int unsigned BE_W = DATA_W / 8;
    localparam int unsigned SC_W = $clog2(STARVE_MAX + 1);
    localparam int unsigned WC_W = $clog2(TIMEOUT + 1);

    localparam logic [SC_W-1:0] STARVE_TOP = SC_W'(STARVE_MAX);
    localparam logic [WC_W-1:0] WAIT_LAST  = WC_W'(TIMEOUT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;

    logic [1:0]        state_q,     state_d;
    logic [SC_W-1:0]   starve_q,    starve_d;
    logic [WC_W-1:0]   wait_q,      wait_d;
    logic              mem_we_q,    mem_we_d;
    logic [BE_W-1:0]   mem_be_q,    mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_done_q,   if_done_d;
    logic              if_err_q,    if_err_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic              dm_done_q,   dm_done_d;
    logic              dm_err_q,    dm_err_d;
    logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;

    logic if_elig, dm_elig, grant_if, grant_dm;

    // A requester whose done is showing is not re-granted; the other one may be.
    assign if_elig  = if_req && !if_done_q;
    assign dm_elig  = dm_req && !dm_done_q;
    assign grant_if = if_elig && (!dm_elig || (starve_q == STARVE_TOP));
    assign grant_dm = dm_elig && !grant_if;

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        wait_d      = wait_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_done_d   = 1'b0;
        if_err_d    = 1'b0;
        dm_done_d   = 1'b0;
        dm_err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_if) begin
                    state_d     = FETCH;
                    wait_d      = '0;
                    starve_d    = '0;
                    mem_we_d    = 1'b0;
                    mem_be_d    = '1;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                end else if (grant_dm) begin
                    state_d     = DATA;
                    wait_d      = '0;
                    mem_we_d    = dm_we;
                    mem_be_d    = dm_be;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    if (if_req && (starve_q != STARVE_TOP)) begin
                        starve_d = starve_q + SC_W'(1);
                    end
                end
            end

            FETCH, DATA: begin
                if (mem_ack) begin
                    state_d = IDLE;
                    if (state_q == FETCH) begin
                        if_rdata_d = mem_rdata;
                        if_done_d  = 1'b1;
                    end else begin
                        if (!mem_we_q) begin
                            dm_rdata_d = mem_rdata;
                        end
                        dm_done_d = 1'b1;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    // This cycle would bring the wait count to TIMEOUT: abort now.
                    state_d = IDLE;
                    if (state_q == FETCH) begin
                        if_done_d = 1'b1;
                        if_err_d  = 1'b1;
                    end else begin
                        dm_done_d = 1'b1;
                        dm_err_d  = 1'b1;
                    end
                end else begin
                    wait_d = wait_q + WC_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            wait_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_done_q   <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_done_q   <= 1'b0;
            dm_err_q    <= 1'b0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            wait_q      <= wait_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_done_q   <= if_done_d;
            if_err_q    <= if_err_d;
            if_rdata_q  <= if_rdata_d;
            dm_done_q   <= dm_done_d;
            dm_err_q    <= dm_err_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign mem_req   = (state_q != IDLE);
    assign busy      = (state_q != IDLE);
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_done   = if_done_q;
    assign if_err    = if_err_q;
    assign if_rdata  = if_rdata_q;
    assign dm_done   = dm_done_q;
    assign dm_err    = dm_err_q;
    assign dm_rdata  = dm_rdata_q;

    // Protocol invariants for simulation; synthesis ignores them.
    a_done_mutex: assert property (@(posedge clk) !(if_done && dm_done));
    a_attr_stable: assert property (@(posedge clk) disable iff (reset)
        (mem_req && $past(mem_req)) |-> $stable({mem_we, mem_be, mem_addr, mem_wdata}));

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter against a transaction-level
// reference model of the grant/complete/timeout rules.
module tb_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int SMAX = 4;
    localparam int TMO  = 255;

    logic          clk;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_done, if_err;
    logic [DW-1:0] if_rdata;
    logic          dm_req, dm_we;
    logic [BW-1:0] dm_be;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_done, dm_err;
    logic [DW-1:0] dm_rdata;
    logic          mem_req, mem_we;
    logic [BW-1:0] mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_err(if_err), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_done(dm_done), .dm_err(dm_err), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the port, how long it has waited, and how many
    // data grants the fetch side has sat through.
    int            r_owner;   // 0 none, 1 fetch, 2 data
    int            r_age;
    int            r_streak;
    bit            r_if_done, r_if_err, r_dm_done, r_dm_err;
    logic [DW-1:0] r_if_rdata, r_dm_rdata;
    logic          r_we;
    logic [BW-1:0] r_be;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;

    task automatic model_step();
        bit want_if, want_dm;
        if (reset) begin
            r_owner = 0; r_age = 0; r_streak = 0;
            r_if_done = 0; r_if_err = 0; r_dm_done = 0; r_dm_err = 0;
            r_if_rdata = '0; r_dm_rdata = '0;
            r_we = 1'b0; r_be = '0; r_addr = '0; r_wdata = '0;
            return;
        end
        want_if = if_req && !r_if_done;
        want_dm = dm_req && !r_dm_done;
        r_if_done = 0; r_if_err = 0; r_dm_done = 0; r_dm_err = 0;
        if (r_owner == 0) begin
            if (want_if && (!want_dm || r_streak >= SMAX)) begin
                r_owner = 1; r_age = 0; r_streak = 0;
                r_we = 1'b0; r_be = '1; r_addr = if_addr; r_wdata = '0;
            end else if (want_dm) begin
                r_owner = 2; r_age = 0;
                if (if_req && r_streak < SMAX) r_streak++;
                r_we = dm_we; r_be = dm_be; r_addr = dm_addr; r_wdata = dm_wdata;
            end
        end else if (mem_ack) begin
            if (r_owner == 1) begin
                r_if_rdata = mem_rdata; r_if_done = 1;
            end else begin
                if (!r_we) r_dm_rdata = mem_rdata;
                r_dm_done = 1;
            end
            r_owner = 0;
        end else begin
            r_age++;
            if (r_age >= TMO) begin
                if (r_owner == 1) begin r_if_done = 1; r_if_err = 1; end
                else begin r_dm_done = 1; r_dm_err = 1; end
                r_owner = 0;
            end
        end
    endtask

    task automatic compare_all(input string ph);
        check_eq({ph, ":mem_req"},   64'(mem_req),   64'(r_owner != 0));
        check_eq({ph, ":busy"},      64'(busy),      64'(r_owner != 0));
        check_eq({ph, ":if_done"},   64'(if_done),   64'(r_if_done));
        check_eq({ph, ":if_err"},    64'(if_err),    64'(r_if_err));
        check_eq({ph, ":if_rdata"},  64'(if_rdata),  64'(r_if_rdata));
        check_eq({ph, ":dm_done"},   64'(dm_done),   64'(r_dm_done));
        check_eq({ph, ":dm_err"},    64'(dm_err),    64'(r_dm_err));
        check_eq({ph, ":dm_rdata"},  64'(dm_rdata),  64'(r_dm_rdata));
        check_eq({ph, ":mem_we"},    64'(mem_we),    64'(r_we));
        check_eq({ph, ":mem_be"},    64'(mem_be),    64'(r_be));
        check_eq({ph, ":mem_addr"},  64'(mem_addr),  64'(r_addr));
        check_eq({ph, ":mem_wdata"}, 64'(mem_wdata), 64'(r_wdata));
        check_eq({ph, ":done_mutex"}, 64'(if_done & dm_done), 64'(0));
    endtask

    logic [AW-1:0] grants[$];

    task automatic tick(input string ph);
        logic prev_req;
        prev_req = mem_req;
        model_step();
        @(posedge clk);
        #1;
        compare_all(ph);
        if (mem_req === 1'b1 && prev_req !== 1'b1) grants.push_back(mem_addr);
    endtask

    int            done_at, rise_at, nf, nd, n1, n2, n_high;
    bit            seen;
    logic [DW-1:0] got_rd, saved_rd;
    int unsigned   ack_pct;
    int unsigned   pct_tbl[4] = '{100, 50, 15, 0};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;

        repeat (3) tick("reset");
        reset = 1'b0;
        tick("idle");

        // Single fetch, ack one cycle after mem_req rises.
        if_req = 1'b1; if_addr = 32'h100; mem_rdata = 32'hDEADBEEF; done_at = -1;
        for (int c = 1; c <= 6; c++) begin
            mem_ack = (r_owner != 0 && r_age == 1);
            tick("fetch");
            if (c == 1) begin
                check_eq("t017_mem_addr", 64'(mem_addr), 64'h100);
                check_eq("t017_mem_we", 64'(mem_we), 64'(0));
            end
            if (if_done === 1'b1 && done_at < 0) begin
                done_at = c; got_rd = if_rdata; if_req = 1'b0;
                check_eq("t017_if_err", 64'(if_err), 64'(0));
            end
        end
        check_eq("t017_done_cycle", 64'(done_at), 64'(3));
        check_eq("t017_if_rdata", 64'(got_rd), 64'hDEADBEEF);
        mem_ack = 1'b0;
        tick("gap");

        // Simultaneous store and fetch with zero-wait ack.
        grants.delete();
        mem_ack = 1'b1; mem_rdata = 32'h0BAD0BAD;
        if_req = 1'b1; if_addr = 32'h300;
        dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'hF; dm_addr = 32'h200; dm_wdata = 32'h12345678;
        done_at = -1; rise_at = -1;
        for (int c = 1; c <= 8; c++) begin
            tick("simul");
            if (dm_done === 1'b1) begin done_at = c; dm_req = 1'b0; end
            if (if_done === 1'b1) if_req = 1'b0;
            if (mem_req === 1'b1 && mem_addr == 32'h300 && rise_at < 0) rise_at = c;
        end
        check_eq("t018_ngrants", 64'(grants.size()), 64'(2));
        if (grants.size() >= 2) begin
            check_eq("t018_first", 64'(grants[0]), 64'h200);
            check_eq("t018_second", 64'(grants[1]), 64'h300);
        end
        check_eq("t018_fetch_after_dm_done", 64'(rise_at), 64'(done_at + 1));

        // Starvation relief: data held, fetch requested except in dm_done cycles.
        grants.delete();
        mem_ack = 1'b1; dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h200;
        if_addr = 32'h300;
        for (int c = 0; c < 60; c++) begin
            if_req = !r_dm_done;
            mem_rdata = $urandom;
            tick("starve");
        end
        nf = 0; nd = 0; n1 = -1; n2 = -1;
        foreach (grants[i]) begin
            if (grants[i] == 32'h300) begin
                if (nf == 0) n1 = nd;
                else if (nf == 1) n2 = nd;
                nf++; nd = 0;
            end else begin
                nd++;
            end
        end
        check_eq("t019_data_before_fetch1", 64'(n1), 64'(SMAX));
        check_eq("t019_data_before_fetch2", 64'(n2), 64'(SMAX));
        if_req = 1'b0; dm_req = 1'b0;
        repeat (3) tick("drain");

        // Timeout on a load.
        saved_rd = r_dm_rdata;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h400; mem_ack = 1'b0; mem_rdata = 32'h55AA55AA;
        n_high = 0; seen = 0; got_rd = '0;
        for (int c = 0; c < 300 && !seen; c++) begin
            tick("timeout");
            if (mem_req === 1'b1) n_high++;
            if (dm_done === 1'b1) begin
                seen = 1; got_rd = dm_rdata; dm_req = 1'b0;
                check_eq("t020_dm_err", 64'(dm_err), 64'(1));
            end
        end
        check_eq("t020_done_seen", 64'(seen), 64'(1));
        check_eq("t020_mem_req_cycles", 64'(n_high), 64'(TMO));
        check_eq("t020_rdata_kept", 64'(got_rd), 64'(saved_rd));
        mem_ack = 1'b1;
        repeat (4) tick("late_ack");

        // Reset two cycles into a fetch, then a fresh fetch.
        mem_ack = 1'b0; if_req = 1'b1; if_addr = 32'h500;
        tick("pre_rst");
        tick("pre_rst");
        reset = 1'b1;
        tick("mid_rst");
        check_eq("t021_mem_req", 64'(mem_req), 64'(0));
        check_eq("t021_if_done", 64'(if_done), 64'(0));
        check_eq("t021_outputs", 64'({busy, mem_addr, if_rdata}), 64'(0));
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFE0001;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick("post_rst");
            if (if_done === 1'b1) begin seen = 1; got_rd = if_rdata; if_req = 1'b0; end
        end
        check_eq("t021_done_seen", 64'(seen), 64'(1));
        check_eq("t021_if_rdata", 64'(got_rd), 64'hCAFE0001);

        // Random traffic.
        ack_pct = 100;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 500 == 0) ack_pct = pct_tbl[$urandom_range(0, 3)];
            reset     = ($urandom_range(0, 499) == 0);
            mem_ack   = ($urandom_range(0, 99) < ack_pct);
            mem_rdata = $urandom;
            if (r_owner == 1) if_req = 1'b1;
            else if (r_if_done || !if_req) begin
                if_req  = ($urandom_range(0, 2) == 0);
                if_addr = $urandom;
            end else if ($urandom_range(0, 15) == 0) if_req = 1'b0;
            if (r_owner == 2) dm_req = 1'b1;
            else if (r_dm_done || !dm_req) begin
                dm_req   = ($urandom_range(0, 1) == 0);
                dm_we    = 1'($urandom_range(0, 1));
                dm_be    = BW'($urandom);
                dm_addr  = $urandom;
                dm_wdata = $urandom;
            end else if ($urandom_range(0, 15) == 0) dm_req = 1'b0;
            tick("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
